alu_multiword_seq: RTL and testbench

Sequencer that runs multi-word (NUM_WORDS x ALU width) arithmetic, logic and rotate operations on the existing single-word combinational alu, one word per clock. Carry is chained through proc flags using the ALU's adc/sbc/rolc/rorc operations. The sequencer sits between the instruction control logic (the requester) and the alu instance, and exclusively drives the alu's oper, a_in, b_in and proc_flags_in inputs.

---
 rtl/alu_multiword_seq.sv | 198 +++++++++++++++++++
 tb/tb_alu_multiword_seq.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_multiword_seq.sv
// Runs NUM_WORDS-wide arithmetic/logic/rotate operations on the single-word alu, one word per clock.
// Optional macro ALU_MW_SEQ_ABORT_EN adds the abort input and aborted pulse output.
//   state | meaning
//   IDLE  | waiting for start; alu inputs parked at add/0
//   RUN   | one operand word per cycle, carry chained through proc flags
//   DONE  | aggregate flags; done pulses as result/flags_out land

`ifndef CONST_ALU_INOUT_WIDTH
`define CONST_ALU_INOUT_WIDTH 8
`endif
`ifndef CONST_PROC_FLAGS_WIDTH
`define CONST_PROC_FLAGS_WIDTH 4
`endif
`ifndef CONST_ALU_OPER_WIDTH
`define CONST_ALU_OPER_WIDTH 4
`define ENUM_ALU_OPER_ADD  4'd0
`define ENUM_ALU_OPER_ADC  4'd1
`define ENUM_ALU_OPER_SUB  4'd2
`define ENUM_ALU_OPER_SBC  4'd3
`define ENUM_ALU_OPER_AND  4'd4
`define ENUM_ALU_OPER_ORR  4'd5
`define ENUM_ALU_OPER_XOR  4'd6
`define ENUM_ALU_OPER_ROLC 4'd7
`define ENUM_ALU_OPER_RORC 4'd8
`endif

module alu_multiword_seq #(
    parameter int NUM_WORDS = 2,
    parameter int W         = `CONST_ALU_INOUT_WIDTH,
    parameter int FW        = `CONST_PROC_FLAGS_WIDTH
) (
    input  logic                             master_clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic [2:0]                       mw_op,
    input  logic [1:0]                       mw_shift,
    input  logic [NUM_WORDS*W-1:0]           a_in,
    input  logic [NUM_WORDS*W-1:0]           b_in,
    input  logic                             carry_in,
`ifdef ALU_MW_SEQ_ABORT_EN
    input  logic                             abort,
    output logic                             aborted,
`endif
    output logic                             busy,
    output logic                             done,
    output logic [NUM_WORDS*W-1:0]           result,
    output logic [FW-1:0]                    flags_out,
    output logic [`CONST_ALU_OPER_WIDTH-1:0] alu_oper,
    output logic [W-1:0]                     alu_a_in,
    output logic [W-1:0]                     alu_b_in,
    output logic [FW-1:0]                    alu_proc_flags_in,
    input  logic [W-1:0]                     alu_out,
    input  logic [FW-1:0]                    alu_proc_flags_out
);
    localparam int OW = `CONST_ALU_OPER_WIDTH;
    localparam int IW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_WORDS - 1);
    localparam int pf_slot_c = 0;
    localparam int pf_slot_z = 1;
    localparam int pf_slot_n = 2;
    localparam int pf_slot_v = 3;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state_q, state_d;

    logic [NUM_WORDS*W-1:0] a_q, b_q;
    logic [2:0]             op_q;
    logic [1:0]             shift_q;
    logic                   cin_q, first_q, c_chain_q, z_acc_q, n_q, v_q;
    logic [IW-1:0]          idx_q, left_q;
    logic                   abort_run, cin_used, is_cmp;
    logic [OW-1:0]          oper_sel;
    logic [FW-1:0]          flags_agg;

`ifdef ALU_MW_SEQ_ABORT_EN
    assign abort_run = abort;
`else
    assign abort_run = 1'b0;
`endif

    assign busy     = (state_q == RUN);
    assign cin_used = (shift_q != 2'd0) || (op_q == 3'd1) || (op_q == 3'd3);
    assign is_cmp   = (shift_q == 2'd0) && (op_q == 3'd4);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (abort_run) state_d = IDLE;
                     else if (left_q == '0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        oper_sel = `ENUM_ALU_OPER_ADD;
        if (shift_q == 2'd1)      oper_sel = `ENUM_ALU_OPER_ROLC;
        else if (shift_q == 2'd2) oper_sel = `ENUM_ALU_OPER_RORC;
        else begin
            case (op_q)
                3'd0:       oper_sel = first_q ? `ENUM_ALU_OPER_ADD : `ENUM_ALU_OPER_ADC;
                3'd1:       oper_sel = `ENUM_ALU_OPER_ADC;
                3'd2, 3'd4: oper_sel = first_q ? `ENUM_ALU_OPER_SUB : `ENUM_ALU_OPER_SBC;
                3'd3:       oper_sel = `ENUM_ALU_OPER_SBC;
                3'd5:       oper_sel = `ENUM_ALU_OPER_AND;
                3'd6:       oper_sel = `ENUM_ALU_OPER_ORR;
                default:    oper_sel = `ENUM_ALU_OPER_XOR;
            endcase
        end
    end

    always_comb begin
        alu_oper          = `ENUM_ALU_OPER_ADD;
        alu_a_in          = '0;
        alu_b_in          = '0;
        alu_proc_flags_in = '0;
        if (state_q == RUN) begin
            alu_oper = oper_sel;
            alu_a_in = a_q[int'(idx_q)*W +: W];
            alu_b_in = (shift_q == 2'd0) ? b_q[int'(idx_q)*W +: W] : '0;
            alu_proc_flags_in[pf_slot_c] = first_q ? (cin_used & cin_q) : c_chain_q;
        end
    end

    always_comb begin
        flags_agg            = '0;
        flags_agg[pf_slot_c] = c_chain_q;
        flags_agg[pf_slot_z] = z_acc_q;
        flags_agg[pf_slot_n] = n_q;
        flags_agg[pf_slot_v] = v_q;
    end

    always_ff @(posedge master_clk) begin
        if (reset) begin
            state_q   <= IDLE;
            done      <= 1'b0;
            result    <= '0;
            flags_out <= '0;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            shift_q   <= '0;
            cin_q     <= 1'b0;
            first_q   <= 1'b0;
            c_chain_q <= 1'b0;
            z_acc_q   <= 1'b1;
            n_q       <= 1'b0;
            v_q       <= 1'b0;
            idx_q     <= '0;
            left_q    <= '0;
`ifdef ALU_MW_SEQ_ABORT_EN
            aborted   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            done    <= 1'b0;
`ifdef ALU_MW_SEQ_ABORT_EN
            aborted <= 1'b0;
`endif
            case (state_q)
                IDLE: if (start) begin
                    a_q     <= a_in;
                    b_q     <= b_in;
                    op_q    <= mw_op;
                    shift_q <= (mw_shift == 2'd3) ? 2'd0 : mw_shift;
                    cin_q   <= carry_in;
                    first_q <= 1'b1;
                    z_acc_q <= 1'b1;
                    left_q  <= LAST_IDX;
                    idx_q   <= (mw_shift == 2'd2) ? LAST_IDX : '0;
                end
                RUN: begin
`ifdef ALU_MW_SEQ_ABORT_EN
                    if (abort) aborted <= 1'b1;
`endif
                    if (!abort_run) begin
                        if (!is_cmp) result[int'(idx_q)*W +: W] <= alu_out;
                        c_chain_q <= alu_proc_flags_out[pf_slot_c];
                        z_acc_q   <= z_acc_q & alu_proc_flags_out[pf_slot_z];
                        if (idx_q == LAST_IDX) begin
                            n_q <= alu_proc_flags_out[pf_slot_n];
                            v_q <= alu_proc_flags_out[pf_slot_v];
                        end
                        first_q <= 1'b0;
                        left_q  <= left_q - IW'(1);
                        idx_q   <= (shift_q == 2'd2) ? idx_q - IW'(1) : idx_q + IW'(1);
                    end
                end
                DONE: begin
                    flags_out <= flags_agg;
                    done      <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_multiword_seq.sv
// Scoreboard bench for alu_multiword_seq (2 x 8-bit words) with a behavioural single-word alu attached.
`ifndef CONST_ALU_INOUT_WIDTH
`define CONST_ALU_INOUT_WIDTH 8
`endif
`ifndef CONST_PROC_FLAGS_WIDTH
`define CONST_PROC_FLAGS_WIDTH 4
`endif
`ifndef CONST_ALU_OPER_WIDTH
`define CONST_ALU_OPER_WIDTH 4
`define ENUM_ALU_OPER_ADD  4'd0
`define ENUM_ALU_OPER_ADC  4'd1
`define ENUM_ALU_OPER_SUB  4'd2
`define ENUM_ALU_OPER_SBC  4'd3
`define ENUM_ALU_OPER_AND  4'd4
`define ENUM_ALU_OPER_ORR  4'd5
`define ENUM_ALU_OPER_XOR  4'd6
`define ENUM_ALU_OPER_ROLC 4'd7
`define ENUM_ALU_OPER_RORC 4'd8
`endif

module tb_alu_multiword_seq;
    localparam int NW = 2;
    localparam int W  = 8;
    localparam int FW = 4;
    localparam int OW = `CONST_ALU_OPER_WIDTH;

    logic master_clk = 1'b0;
    logic reset, start, carry_in, busy, done;
    logic [2:0]      mw_op;
    logic [1:0]      mw_shift;
    logic [NW*W-1:0] a_in, b_in, result;
    logic [FW-1:0]   flags_out, alu_proc_flags_in, alu_proc_flags_out;
    logic [OW-1:0]   alu_oper;
    logic [W-1:0]    alu_a_in, alu_b_in, alu_out;
`ifdef ALU_MW_SEQ_ABORT_EN
    logic abort, aborted;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [15:0] res;
        logic [3:0]  flg;
    } exp_t;
    exp_t sb_q[$];
    exp_t mon_e;

    always #5 master_clk = ~master_clk;

    alu_multiword_seq #(.NUM_WORDS(NW), .W(W), .FW(FW)) dut (
        .master_clk(master_clk), .reset(reset), .start(start),
        .mw_op(mw_op), .mw_shift(mw_shift), .a_in(a_in), .b_in(b_in), .carry_in(carry_in),
`ifdef ALU_MW_SEQ_ABORT_EN
        .abort(abort), .aborted(aborted),
`endif
        .busy(busy), .done(done), .result(result), .flags_out(flags_out),
        .alu_oper(alu_oper), .alu_a_in(alu_a_in), .alu_b_in(alu_b_in),
        .alu_proc_flags_in(alu_proc_flags_in), .alu_out(alu_out),
        .alu_proc_flags_out(alu_proc_flags_out)
    );

    // Flags layout {V,N,Z,C}; carry convention: C=1 means no borrow on sub/sbc.
    function automatic logic [FW+W-1:0] alu_f(input logic [OW-1:0] op, input logic [W-1:0] a,
                                              input logic [W-1:0] b, input logic ci);
        logic [W:0]   s;
        logic [W-1:0] o;
        logic         c, v;
        s = '0; v = 1'b0;
        case (op)
            `ENUM_ALU_OPER_ADD:  s = {1'b0, a} + {1'b0, b};
            `ENUM_ALU_OPER_ADC:  s = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
            `ENUM_ALU_OPER_SUB:  s = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, 1'b1};
            `ENUM_ALU_OPER_SBC:  s = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, ci};
            `ENUM_ALU_OPER_AND:  s = {1'b0, a & b};
            `ENUM_ALU_OPER_ORR:  s = {1'b0, a | b};
            `ENUM_ALU_OPER_XOR:  s = {1'b0, a ^ b};
            `ENUM_ALU_OPER_ROLC: s = {a, ci};
            default:             s = '0;
        endcase
        o = s[W-1:0];
        c = s[W];
        if (op == `ENUM_ALU_OPER_RORC) begin
            o = {ci, a[W-1:1]};
            c = a[0];
        end
        if (op == `ENUM_ALU_OPER_ADD || op == `ENUM_ALU_OPER_ADC)
            v = (a[W-1] == b[W-1]) && (o[W-1] != a[W-1]);
        if (op == `ENUM_ALU_OPER_SUB || op == `ENUM_ALU_OPER_SBC)
            v = (a[W-1] != b[W-1]) && (o[W-1] != a[W-1]);
        return {v, o[W-1], (o == '0), c, o};
    endfunction

    assign {alu_proc_flags_out, alu_out} = alu_f(alu_oper, alu_a_in, alu_b_in, alu_proc_flags_in[0]);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge master_clk) begin
        if (done === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_done: got done=1 expected no pending request");
            end else begin
                mon_e = sb_q.pop_front();
                chk("result", result, mon_e.res);
                chk("flags_out", flags_out, mon_e.flg);
            end
        end
    end

    task automatic issue(input string name, input logic [2:0] op, input logic [1:0] sh,
                         input logic [15:0] a, input logic [15:0] b, input logic ci,
                         input logic [15:0] er, input logic [3:0] ef,
                         input bit seq_chk, input logic [7:0] ea0, input logic [7:0] ea1,
                         input bit restart);
        int cnt;
        mw_op = op; mw_shift = sh; a_in = a; b_in = b; carry_in = ci;
        sb_q.push_back(exp_t'({er, ef}));
        start = 1'b1;
        @(posedge master_clk); #1;
        start = 1'b0;
        cnt = 0;
        chk({name, "_busy"}, busy, 1);
        if (seq_chk) chk({name, "_a_seq0"}, alu_a_in, ea0);
        while (done !== 1'b1 && cnt < 12) begin
            if (restart && cnt == 0) begin
                mw_op = 3'd7; a_in = 16'hFFFF; b_in = 16'h0000; start = 1'b1;
            end
            @(posedge master_clk); #1;
            start = 1'b0;
            cnt++;
            if (seq_chk && cnt == 1) chk({name, "_a_seq1"}, alu_a_in, ea1);
        end
        chk({name, "_latency"}, cnt, 3);
        @(posedge master_clk); #1;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; mw_op = '0; mw_shift = '0;
        a_in = '0; b_in = '0; carry_in = 1'b0;
`ifdef ALU_MW_SEQ_ABORT_EN
        abort = 1'b0;
`endif
        repeat (3) @(posedge master_clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_flags", flags_out, 0);
        chk("rst_alu_oper", alu_oper, `ENUM_ALU_OPER_ADD);
        chk("rst_alu_a", alu_a_in, 0);
        chk("rst_alu_b", alu_b_in, 0);
        chk("rst_alu_pf", alu_proc_flags_in, 0);
        reset = 1'b0;
        @(posedge master_clk); #1;

        //    name      op    sh    a         b         ci    result    {V,N,Z,C}
        issue("add",    3'd0, 2'd0, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 4'b0000, 0, 8'h00, 8'h00, 0);
        issue("sub",    3'd2, 2'd0, 16'h0100, 16'h0001, 1'b0, 16'h00FF, 4'b0001, 0, 8'h00, 8'h00, 0);
        issue("preld",  3'd0, 2'd0, 16'hAA00, 16'h00AA, 1'b1, 16'hAAAA, 4'b0100, 0, 8'h00, 8'h00, 0);
        issue("cmp",    3'd4, 2'd0, 16'h1234, 16'h1234, 1'b0, 16'hAAAA, 4'b0011, 0, 8'h00, 8'h00, 0);
        issue("rorc",   3'd0, 2'd2, 16'h0001, 16'h5555, 1'b1, 16'h8000, 4'b0101, 1, 8'h00, 8'h01, 0);
        issue("rolc",   3'd7, 2'd1, 16'h8001, 16'hFFFF, 1'b0, 16'h0002, 4'b0001, 1, 8'h01, 8'h80, 0);
        issue("adc",    3'd1, 2'd0, 16'h00FF, 16'h0000, 1'b1, 16'h0100, 4'b0000, 0, 8'h00, 8'h00, 0);
        issue("xor",    3'd7, 2'd0, 16'hF0F0, 16'hF0F0, 1'b1, 16'h0000, 4'b0010, 0, 8'h00, 8'h00, 0);
        issue("rsv_sh", 3'd5, 2'd3, 16'h0FF0, 16'h00FF, 1'b0, 16'h00F0, 4'b0000, 0, 8'h00, 8'h00, 0);
        issue("sbc",    3'd3, 2'd0, 16'h0000, 16'h0000, 1'b0, 16'hFFFF, 4'b0100, 0, 8'h00, 8'h00, 0);
        issue("restart",3'd0, 2'd0, 16'h0102, 16'h0304, 1'b0, 16'h0406, 4'b0000, 0, 8'h00, 8'h00, 1);
        repeat (3) @(posedge master_clk);
        #1;
        chk("restart_single_done", sb_q.size(), 0);

        mw_op = 3'd0; mw_shift = 2'd0; a_in = 16'h00FF; b_in = 16'h0001; carry_in = 1'b0;
        start = 1'b1;
        @(posedge master_clk); #1;
        start = 1'b0;
        @(posedge master_clk); #1;
        reset = 1'b1;
        @(posedge master_clk); #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_result", result, 0);
        chk("mid_rst_flags", flags_out, 0);
        reset = 1'b0;
        repeat (5) @(posedge master_clk);
        #1;
        issue("post_rst", 3'd0, 2'd0, 16'h7F00, 16'h0100, 1'b0, 16'h8000, 4'b1100, 0, 8'h00, 8'h00, 0);

        repeat (4) @(posedge master_clk);
        #1;
        chk("scoreboard_empty", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
